// File: rtl/soc_mem_pkg.sv
// Shared definitions for the SoC data memory.
//   MAX_RD_LATENCY     : deepest read pipeline the memory supports
//   DEFAULT_DATA_WIDTH : word width used by the SoC-level instance
//   mem_resp_t         : response word {rdata, we, err} at the default width;
//                        soc_data_mem re-declares the same layout at its own
//                        DATA_WIDTH because a package type cannot take a
//                        module parameter.
package soc_mem_pkg;

  localparam int MAX_RD_LATENCY     = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] rdata;
    logic                          we;
    logic                          err;
  } mem_resp_t;

endpackage

// File: rtl/soc_resp_fifo.sv
// Synchronous fall-through FIFO: the head entry is visible on dout whenever
// empty is low, with no extra read cycle.
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-low reset
//   push, din        : write an entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   dout             : head entry, combinational
//   full, empty      : occupancy flags
// Pointers carry one extra wrap bit above the index so full and empty can be
// told apart when the indices match; DEPTH need not be a power of two.
module soc_resp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Index wraps at DEPTH-1 (not at a power of two) and flips the wrap bit.
  function automatic logic [IW:0] next_ptr(input logic [IW:0] p);
    if (p[IW-1:0] == LAST_IDX) begin
      return {~p[IW], {IW{1'b0}}};
    end
    return {p[IW], p[IW-1:0] + IDX_ONE};
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[IW-1:0]] <= din;
  end

endmodule

// File: rtl/soc_data_mem.sv
// Parametrised data memory with valid/ready request and response channels.
// Ports:
//   clk, reset                  : rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready       : request handshake
//   we, addr, wdata, wstrb      : request payload (write enable, word address,
//                                 write data, byte enables)
//   valid_data / resp_ready     : response handshake
//   rdata, resp_we, resp_err    : response payload (all zero while valid_data=0)
// Every accepted request produces exactly one response, in acceptance order.
// Writes commit at the accept edge; reads sample the array at the accept edge
// and the result travels RD_LATENCY-1 register stages before entering a
// fall-through response FIFO. A credit counter bounds outstanding requests to
// RESP_DEPTH, so the FIFO can never overflow.
module soc_data_mem
  import soc_mem_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int MEM_DEPTH  = 64,
  parameter  int RD_LATENCY = 1,
  parameter  int RESP_DEPTH = 4,
  localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    valid_data,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    resp_we,
  output logic                    resp_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CRED_WIDTH = $clog2(RESP_DEPTH + 1);
  localparam logic [CRED_WIDTH-1:0] CRED_MAX    = CRED_WIDTH'(RESP_DEPTH);
  localparam logic [CRED_WIDTH-1:0] CRED_ONE    = CRED_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic                  err;
  } resp_word_t;

  localparam int RESP_WIDTH = $bits(resp_word_t);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_width
    $error("soc_data_mem: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_chk_latency
    $error("soc_data_mem: RD_LATENCY must be within 1..MAX_RD_LATENCY");
  end
  if (RESP_DEPTH < RD_LATENCY + 1) begin : g_chk_depth
    $error("soc_data_mem: RESP_DEPTH must be at least RD_LATENCY+1");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  accept;
  logic                  present;
  logic                  in_range;
  logic                  ready_en;
  logic [CRED_WIDTH-1:0] credits;
  logic                  vld_p0;
  resp_word_t            resp_p0;
  logic                  fifo_push;
  resp_word_t            fifo_din;
  logic [RESP_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  resp_word_t            head;

  assign accept   = req_valid && req_ready;
  assign present  = valid_data && resp_ready;
  assign in_range = ({1'b0, addr} < DEPTH_LIMIT);

  // ready_en holds req_ready low during reset and releases it on the first
  // edge afterwards. fifo_full is implied by credits==RESP_DEPTH; folding it
  // in keeps the FIFO safe even if the two ever disagreed.
  assign req_ready = ready_en && (credits < CRED_MAX) && !fifo_full;

  // Stage p0: accept edge. Writes commit here; reads sample the array here.
  always_ff @(posedge clk) begin
    if (accept && we && in_range) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    vld_p0        = accept;
    resp_p0       = '0;
    resp_p0.we    = we;
    resp_p0.err   = !in_range;
    resp_p0.rdata = (!we && in_range) ? mem[addr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      credits  <= '0;
    end else begin
      ready_en <= 1'b1;
      case ({accept, present})
        2'b10:   credits <= credits + CRED_ONE;
        2'b01:   credits <= credits - CRED_ONE;
        default: credits <= credits;
      endcase
    end
  end

  if (RD_LATENCY == 1) begin : g_no_pipe
    assign fifo_push = vld_p0;
    assign fifo_din  = resp_p0;
  end else begin : g_pipe
    // Stages p1..p(RD_LATENCY-1): element i of the arrays is stage i+1.
    logic       vld_p  [RD_LATENCY-1];
    resp_word_t resp_p [RD_LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p <= '{default: 1'b0};
      end else begin
        vld_p[0] <= vld_p0;
        for (int i = 1; i < RD_LATENCY - 1; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      resp_p[0] <= resp_p0;
      for (int i = 1; i < RD_LATENCY - 1; i++) resp_p[i] <= resp_p[i-1];
    end

    assign fifo_push = vld_p[RD_LATENCY-2];
    assign fifo_din  = resp_p[RD_LATENCY-2];
  end

  // Final stage: response FIFO, written on the last edge of the latency.
  soc_resp_fifo #(
    .WIDTH (RESP_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (present),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head       = fifo_dout;
  assign valid_data = !fifo_empty;
  assign rdata      = valid_data ? head.rdata : '0;
  assign resp_we    = valid_data && head.we;
  assign resp_err   = valid_data && head.err;

endmodule
